// File: rtl/driver_status_fsm.sv
// Run/warn/fault sequencer producing the registered 2-bit status code for the LED decoder.
// Obstacle input is debounced into WARN; a WARN that lasts too long latches FAULT until ack.
module driver_status_fsm #(
  parameter int RUN_TIME   = 10,
  parameter int DEBOUNCE   = 3,
  parameter int WARN_LIMIT = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        obstacle,
  input  logic                        ack,
  output logic [1:0]                  status,
  output logic                        done,
  output logic [$clog2(RUN_TIME)-1:0] run_count
);

  localparam int RC_W = $clog2(RUN_TIME);
  localparam int OC_W = $clog2(DEBOUNCE + 1);
  localparam int WC_W = $clog2(WARN_LIMIT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_WARN  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RUN_TIME - 1);
  localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);
  localparam logic [OC_W-1:0] DB_LAST   = OC_W'(DEBOUNCE - 1);
  localparam logic [OC_W-1:0] DB_ONE    = OC_W'(1);
  localparam logic [WC_W-1:0] WARN_LAST = WC_W'(WARN_LIMIT - 1);
  localparam logic [WC_W-1:0] WARN_ONE  = WC_W'(1);

  logic [1:0]      state_q, state_d;
  logic [RC_W-1:0] run_count_q, run_count_d;
  logic [OC_W-1:0] obs_cnt_q, obs_cnt_d;
  logic [OC_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [WC_W-1:0] warn_cnt_q, warn_cnt_d;
  logic            done_q, done_d;

  always_comb begin
    state_d     = state_q;
    run_count_d = run_count_q;
    obs_cnt_d   = '0;
    clr_cnt_d   = '0;
    warn_cnt_d  = '0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        run_count_d = '0;
        if (start && !stop) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          run_count_d = '0;
        end else if (obstacle && (obs_cnt_q == DB_LAST)) begin
          // run_count is held here and resumes on recovery
          state_d = ST_WARN;
        end else if (run_count_q == RC_LAST) begin
          state_d     = ST_IDLE;
          run_count_d = '0;
          done_d      = 1'b1;
        end else begin
          run_count_d = run_count_q + RC_ONE;
          obs_cnt_d   = obstacle ? (obs_cnt_q + DB_ONE) : '0;
        end
      end

      ST_WARN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          run_count_d = '0;
        end else if (!obstacle && (clr_cnt_q == DB_LAST)) begin
          state_d = ST_RUN;
        end else if (warn_cnt_q == WARN_LAST) begin
          state_d = ST_FAULT;
        end else begin
          warn_cnt_d = warn_cnt_q + WARN_ONE;
          clr_cnt_d  = obstacle ? '0 : (clr_cnt_q + DB_ONE);
        end
      end

      ST_FAULT: begin
        if (ack) begin
          state_d     = ST_IDLE;
          run_count_d = '0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        run_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      run_count_q <= '0;
      obs_cnt_q   <= '0;
      clr_cnt_q   <= '0;
      warn_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_count_q <= run_count_d;
      obs_cnt_q   <= obs_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      warn_cnt_q  <= warn_cnt_d;
      done_q      <= done_d;
    end
  end

  assign status    = state_q;
  assign done      = done_q;
  assign run_count = run_count_q;

endmodule

// File: tb/tb_driver_status_fsm.sv
// Directed bench for driver_status_fsm with default parameters (RUN_TIME=10, DEBOUNCE=3, WARN_LIMIT=6).
module tb_driver_status_fsm;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       obstacle;
  logic       ack;
  logic [1:0] status;
  logic       done;
  logic [3:0] run_count;

  int errors = 0;
  int checks = 0;

  driver_status_fsm #(
    .RUN_TIME  (10),
    .DEBOUNCE  (3),
    .WARN_LIMIT(6)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .obstacle (obstacle),
    .ack      (ack),
    .status   (status),
    .done     (done),
    .run_count(run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int st, input int dn, input int rc);
    check({tag, ".status"}, int'(status), st);
    check({tag, ".done"}, int'(done), dn);
    check({tag, ".run_count"}, int'(run_count), rc);
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    obstacle = 1'b0;
    ack      = 1'b0;
    #12;
    expect_out("reset", 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Nominal run: 10 RUN cycles counting 0..9, then one done pulse in IDLE
    start_run();
    for (int i = 0; i < 10; i++) begin
      expect_out($sformatf("run%0d", i), 1, 0, i);
      tick();
    end
    expect_out("run_done", 0, 1, 0);
    tick();
    expect_out("after_done", 0, 0, 0);

    // Debounce: two obstacle cycles do not trigger WARN, three do
    start_run();
    repeat (4) tick();
    expect_out("db_rc4", 1, 0, 4);
    obstacle = 1'b1;
    tick();
    tick();
    obstacle = 1'b0;
    tick();
    expect_out("db_short", 1, 0, 7);
    obstacle = 1'b1;
    tick();
    tick();
    expect_out("db_two", 1, 0, 9);
    tick();
    expect_out("db_warn", 2, 0, 9);

    // Recovery after three clear cycles, run resumes at the frozen count
    obstacle = 1'b0;
    tick();
    tick();
    expect_out("rec_pending", 2, 0, 9);
    tick();
    expect_out("rec_run", 1, 0, 9);
    tick();
    expect_out("rec_done", 0, 1, 0);
    tick();

    // Escalation: WARN held for 6 cycles latches FAULT
    start_run();
    obstacle = 1'b1;
    tick();
    tick();
    tick();
    expect_out("esc_warn", 2, 0, 2);
    for (int i = 1; i < 6; i++) begin
      tick();
      check($sformatf("esc_hold%0d.status", i), int'(status), 2);
    end
    tick();
    check("esc_fault.status", int'(status), 3);
    start = 1'b1;
    stop = 1'b1;
    obstacle = 1'b0;
    tick();
    tick();
    check("fault_latched.status", int'(status), 3);
    start = 1'b0;
    stop = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    expect_out("ack_idle", 0, 0, 0);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    expect_out("start_stop", 0, 0, 0);

    // stop on the completing edge suppresses done
    start_run();
    repeat (9) tick();
    expect_out("pre_complete", 1, 0, 9);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_out("stop_complete", 0, 0, 0);

    // stop on the debounce trigger edge wins
    start_run();
    obstacle = 1'b1;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    obstacle = 1'b0;
    expect_out("stop_debounce", 0, 0, 0);

    // Asynchronous reset in WARN
    start_run();
    obstacle = 1'b1;
    repeat (3) tick();
    check("pre_rst_warn.status", int'(status), 2);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("rst_warn", 0, 0, 0);
    obstacle = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    start_run();
    expect_out("rst_warn_restart", 1, 0, 0);

    // Asynchronous reset in RUN
    repeat (3) tick();
    check("pre_rst_run.run_count", int'(run_count), 3);
    #3;
    reset_n = 1'b0;
    #1;
    expect_out("rst_run", 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    start_run();
    expect_out("rst_run_restart", 1, 0, 0);
    tick();
    check("rst_run_count1", int'(run_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
